// File: rtl/rf_access_seq_pkg.sv
// Shared definitions for the register-bank access sequencer: default sizes,
// FSM state encodings and a small address range helper.
package rf_access_seq_pkg;

    localparam int NREGS_DEF = 8;
    localparam int AW_DEF    = 3;
    localparam int DW_DEF    = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRIVE    = 3'd1;
    localparam logic [2:0] ST_CAPTURE  = 3'd2;
    localparam logic [2:0] ST_PRESENT  = 3'd3;
    localparam logic [2:0] ST_WAIT_RES = 3'd4;
    localparam logic [2:0] ST_WRITE    = 3'd5;

    function automatic logic addr_in_range(input logic [31:0] addr, input int nregs);
        return addr < 32'(nregs);
    endfunction

endpackage

// File: rtl/rf_access_seq_onehot_dec.sv
// Gated binary-to-one-hot decoder; addresses at or beyond NREGS decode to all-zero.
module rf_access_seq_onehot_dec #(
    parameter int AW    = 3,
    parameter int NREGS = 8
) (
    input  logic [AW-1:0]    addr,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en && (addr == AW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_access_seq.sv
// Operand-fetch / writeback sequencer in front of the reg16 bank: drives
// the bus enables, captures DA/DB, hands operands off and issues the load strobe.
module rf_access_seq
    import rf_access_seq_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    sa,
    input  logic [AW-1:0]    sb,
    input  logic [AW-1:0]    dest,
    input  logic             wb_en,
    output logic [NREGS-1:0] oeA,
    output logic [NREGS-1:0] oeB,
    output logic [NREGS-1:0] ld,
    output logic [DW-1:0]    Din,
    input  logic [DW-1:0]    DA,
    input  logic [DW-1:0]    DB,
    output logic [DW-1:0]    opA,
    output logic [DW-1:0]    opB,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic             res_valid,
    input  logic [DW-1:0]    res_data,
    output logic             res_ready
);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] sa_q, sa_d, sb_q, sb_d, dest_q, dest_d;
    logic          wb_en_q, wb_en_d;
    logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d, din_q, din_d;
    logic          oe_en, ld_en;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dest_d  = dest_q;
        wb_en_d = wb_en_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    sa_d    = sa;
                    sb_d    = sb;
                    dest_d  = dest;
                    wb_en_d = wb_en;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                // A bus with no enabled driver floats, so out-of-range reads yield zero.
                op_a_d  = addr_in_range(32'(sa_q), NREGS) ? DA : '0;
                op_b_d  = addr_in_range(32'(sb_q), NREGS) ? DB : '0;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (op_ready) begin
                    state_d = wb_en_q ? ST_WAIT_RES : ST_IDLE;
                end
            end
            ST_WAIT_RES: begin
                if (res_valid) begin
                    din_d   = res_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            dest_q  <= '0;
            wb_en_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dest_q  <= dest_d;
            wb_en_q <= wb_en_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            din_q   <= din_d;
        end
    end

    // Strobes come only from state and latched addresses, so reset kills them at once.
    assign oe_en = (state_q == ST_DRIVE) || (state_q == ST_CAPTURE);
    assign ld_en = (state_q == ST_WRITE);

    rf_access_seq_onehot_dec #(.AW(AW), .NREGS(NREGS)) u_dec_oea (
        .addr(sa_q), .en(oe_en), .onehot(oeA)
    );
    rf_access_seq_onehot_dec #(.AW(AW), .NREGS(NREGS)) u_dec_oeb (
        .addr(sb_q), .en(oe_en), .onehot(oeB)
    );
    rf_access_seq_onehot_dec #(.AW(AW), .NREGS(NREGS)) u_dec_ld (
        .addr(dest_q), .en(ld_en), .onehot(ld)
    );

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign op_valid  = (state_q == ST_PRESENT);
    assign res_ready = (state_q == ST_WAIT_RES);
    assign opA       = op_a_q;
    assign opB       = op_b_q;
    assign Din       = din_q;

endmodule

// File: tb/tb_rf_access_seq.sv
// Self-checking bench: six-register bank model on DA/DB, table of fetch
// requests with a scoreboard for operands, plus hand-written reset sequences.
module tb_rf_access_seq;

    localparam int NR = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, wb_en, op_valid, op_ready, res_valid, res_ready;
    logic [2:0]  sa, sb, dest;
    logic [5:0]  oe_a, oe_b, ld;
    logic [15:0] din, bus_a, bus_b, op_a, op_b, res_data;

    logic [15:0] bank [NR] = '{16'h0000, 16'h1234, 16'h5555, 16'h00FF, 16'h0011, 16'hABCD};

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] exp_q [$];
    logic [15:0] exp_din;

    typedef struct {
        logic [2:0]  sa, sb, dest;
        logic        wb;
        int          stall;
        logic [15:0] res, exp_opa, exp_opb;
        logic [5:0]  exp_oea, exp_oeb, exp_ld;
    } req_t;

    req_t vecs [9];

    always #5 clk = ~clk;

    rf_access_seq #(.NREGS(NR), .AW(3), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .sa(sa), .sb(sb), .dest(dest), .wb_en(wb_en),
        .oeA(oe_a), .oeB(oe_b), .ld(ld), .Din(din),
        .DA(bus_a), .DB(bus_b), .opA(op_a), .opB(op_b),
        .op_valid(op_valid), .op_ready(op_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    // Undriven buses idle at a recognisable non-zero value.
    always_comb begin
        bus_a = 16'hBAD0;
        bus_b = 16'hBAD0;
        for (int i = 0; i < NR; i++) begin
            if (oe_a[i]) bus_a = bank[i];
            if (oe_b[i]) bus_b = bank[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (ld[i]) bank[i] <= din;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_and_compare(input int idx);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_output($sformatf("vec%0d scoreboard underflow", idx), 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_output($sformatf("vec%0d opA", idx), 32'(op_a), 32'(e[31:16]));
            check_output($sformatf("vec%0d opB", idx), 32'(op_b), 32'(e[15:0]));
        end
    endtask

    task automatic apply_stimulus(input req_t r, input int idx);
        int n = 0, busy = 0, oe_cyc = 0, ld_cyc = 0, ov_cyc = 0, stall_cnt = 0;
        logic [5:0] oea_seen = '0, oeb_seen = '0, ld_seen = '0;
        logic multi = 1'b0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("vec%0d req_ready before accept", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        sa = r.sa; sb = r.sb; dest = r.dest; wb_en = r.wb;
        op_ready  = (r.stall == 0);
        res_valid = 1'b1;
        res_data  = ~r.res;
        exp_q.push_back({r.exp_opa, r.exp_opb});
        @(negedge clk);
        req_valid = 1'b0;
        sa = ~r.sa; sb = ~r.sb; dest = ~r.dest; wb_en = ~r.wb;
        while (!req_ready && busy < 60) begin
            busy++;
            if (oe_a != 0 || oe_b != 0) oe_cyc++;
            oea_seen |= oe_a;
            oeb_seen |= oe_b;
            if ($countones(oe_a) > 1 || $countones(oe_b) > 1 || $countones(ld) > 1) multi = 1'b1;
            if (ld != 0) ld_cyc++;
            ld_seen |= ld;
            if (op_valid) begin
                ov_cyc++;
                if (stall_cnt < r.stall) begin
                    op_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    op_ready = 1'b1;
                end
                if (op_ready) pop_and_compare(idx);
            end
            res_data = res_ready ? r.res : ~r.res;
            @(negedge clk);
        end
        if (r.wb) exp_din = r.res;
        check_output($sformatf("vec%0d busy cycles", idx), 32'(busy), 32'(3 + r.stall + (r.wb ? 2 : 0)));
        check_output($sformatf("vec%0d oe cycles", idx), 32'(oe_cyc), 32'd2);
        check_output($sformatf("vec%0d oeA", idx), 32'(oea_seen), 32'(r.exp_oea));
        check_output($sformatf("vec%0d oeB", idx), 32'(oeb_seen), 32'(r.exp_oeb));
        check_output($sformatf("vec%0d ld", idx), 32'(ld_seen), 32'(r.exp_ld));
        check_output($sformatf("vec%0d ld cycles", idx), 32'(ld_cyc), (r.exp_ld != 0) ? 32'd1 : 32'd0);
        check_output($sformatf("vec%0d op_valid cycles", idx), 32'(ov_cyc), 32'(1 + r.stall));
        check_output($sformatf("vec%0d multi-hot", idx), 32'(multi), 32'd0);
        check_output($sformatf("vec%0d Din", idx), 32'(din), 32'(exp_din));
    endtask

    initial begin
        int n;
        vecs[0] = '{3'd1, 3'd5, 3'd0, 1'b0, 0, 16'h0000, 16'h1234, 16'hABCD, 6'h02, 6'h20, 6'h00};
        vecs[1] = '{3'd3, 3'd3, 3'd0, 1'b0, 0, 16'h0000, 16'h00FF, 16'h00FF, 6'h08, 6'h08, 6'h00};
        vecs[2] = '{3'd4, 3'd0, 3'd4, 1'b1, 3, 16'h7777, 16'h0011, 16'h0000, 6'h10, 6'h01, 6'h10};
        vecs[3] = '{3'd4, 3'd2, 3'd0, 1'b0, 1, 16'h0000, 16'h7777, 16'h5555, 6'h10, 6'h04, 6'h00};
        vecs[4] = '{3'd7, 3'd1, 3'd6, 1'b1, 0, 16'h4242, 16'h0000, 16'h1234, 6'h00, 6'h02, 6'h00};
        vecs[5] = '{3'd6, 3'd4, 3'd2, 1'b1, 2, 16'h0BEE, 16'h0000, 16'h7777, 6'h00, 6'h10, 6'h04};
        vecs[6] = '{3'd2, 3'd7, 3'd0, 1'b0, 0, 16'h0000, 16'h0BEE, 16'h0000, 6'h04, 6'h00, 6'h00};
        vecs[7] = '{3'd5, 3'd1, 3'd1, 1'b1, 0, 16'hC0DE, 16'hABCD, 16'h1234, 6'h20, 6'h02, 6'h02};
        vecs[8] = '{3'd1, 3'd1, 3'd0, 1'b0, 0, 16'h0000, 16'hC0DE, 16'hC0DE, 6'h02, 6'h02, 6'h00};

        reset = 1'b1;
        req_valid = 1'b0; sa = '0; sb = '0; dest = '0; wb_en = 1'b0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        exp_din = '0;
        repeat (2) @(negedge clk);
        check_output("reset oeA", 32'(oe_a), 32'd0);
        check_output("reset oeB", 32'(oe_b), 32'd0);
        check_output("reset ld", 32'(ld), 32'd0);
        check_output("reset opA/opB", {op_a, op_b}, 32'd0);
        check_output("reset Din", 32'(din), 32'd0);
        check_output("reset op_valid/res_ready", {30'd0, op_valid, res_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("req_ready after reset", 32'(req_ready), 32'd1);

        // Reset while the enables are driving.
        req_valid = 1'b1; sa = 3'd2; sb = 3'd3; dest = 3'd0; wb_en = 1'b0;
        @(posedge clk);
        #2;
        check_output("drive oeA", 32'(oe_a), 32'h04);
        reset = 1'b1;
        #1;
        check_output("async reset oeA", 32'(oe_a), 32'd0);
        check_output("async reset oeB", 32'(oe_b), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_output("post-reset req_ready", 32'(req_ready), 32'd1);
        check_output("post-reset op_valid", 32'(op_valid), 32'd0);
        check_output("post-reset opA", 32'(op_a), 32'd0);

        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], i);
        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // Reset while the load strobe is up.
        @(negedge clk);
        req_valid = 1'b1; sa = 3'd0; sb = 3'd0; dest = 3'd3; wb_en = 1'b1;
        op_ready = 1'b1; res_valid = 1'b1; res_data = 16'h9999;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (ld == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("write ld", 32'(ld), 32'h08);
        check_output("write Din", 32'(din), 32'h9999);
        #2;
        reset = 1'b1;
        #1;
        check_output("reset in WRITE ld", 32'(ld), 32'd0);
        check_output("reset in WRITE Din", 32'(din), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        op_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        check_output("req_ready after WRITE reset", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
